// File: rtl/ch2_sipo_frame_ctrl.sv
// ch2_sipo_frame_ctrl: framed serial receiver built around a WIDTH-bit SIPO shift path.
// It hunts for a start bit, shifts in WIDTH data bits MSB-first and checks the stop bit.
// Each good word is handed over through a one-entry valid/ready buffer.
// Optional feature macro: SIPO_PARITY_EN adds an even-parity bit between data and stop.
module ch2_sipo_frame_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             DATA_IN,
    input  logic             DOUT_READY,
    output logic [WIDTH-1:0] DOUT,
    output logic             DOUT_VALID,
    output logic             BUSY,
    output logic             FRAME_ERR,
    output logic             OVERRUN
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
`ifdef SIPO_PARITY_EN
        ST_PAR  = 2'd2,
`endif
        ST_STOP = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             busy_q, busy_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             par_bad;

`ifdef SIPO_PARITY_EN
    logic             par_err_q, par_err_d;
    assign par_bad = par_err_q;
`else
    assign par_bad = 1'b0;
`endif

    // State and datapath registers; synchronous reset drops any partial frame.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef SIPO_PARITY_EN
            par_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef SIPO_PARITY_EN
            par_err_q    <= par_err_d;
`endif
        end
    end

    // Next-state sequencing: IDLE -> DATA (WIDTH bits) -> [PAR] -> STOP -> IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!DATA_IN) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
`ifdef SIPO_PARITY_EN
                    state_d = ST_PAR;
`else
                    state_d = ST_STOP;
`endif
                end
            end
`ifdef SIPO_PARITY_EN
            ST_PAR:  state_d = ST_STOP;
`endif
            ST_STOP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath, output buffer and status pulses, all resolved into registered next values.
    always_comb begin
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
`ifdef SIPO_PARITY_EN
        par_err_d    = par_err_q;
`endif

        // A sampled drain empties the buffer unless a load below refills it.
        if (dout_valid_q && DOUT_READY) dout_valid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!DATA_IN) begin
                    shreg_d = '0;
                    cnt_d   = '0;
`ifdef SIPO_PARITY_EN
                    par_err_d = 1'b0;
`endif
                end
            end
            ST_DATA: begin
                shreg_d = {shreg_q[WIDTH-2:0], DATA_IN};
                // Explicit clear on the last bit so non-power-of-two widths never wrap mid-frame.
                if (cnt_q == CNT_LAST) cnt_d = '0;
                else                   cnt_d = cnt_q + 1'b1;
            end
`ifdef SIPO_PARITY_EN
            ST_PAR: begin
                par_err_d = DATA_IN ^ (^shreg_q);
            end
`endif
            ST_STOP: begin
                if (!DATA_IN || par_bad) begin
                    frame_err_d = 1'b0 | 1'b1;
                end else if (!dout_valid_q || DOUT_READY) begin
                    dout_d       = shreg_q;
                    dout_valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                shreg_d = shreg_q;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign DOUT       = dout_q;
    assign DOUT_VALID = dout_valid_q;
    assign BUSY       = busy_q;
    assign FRAME_ERR  = frame_err_q;
    assign OVERRUN    = overrun_q;

endmodule
